// File: rtl/intr_gpio_gen.sv
// intr_gpio_gen: multi-channel programmable interrupt/GPIO pulse-train generator.
// Each channel runs an IDLE -> WAIT -> PULSE state machine configured through a
// valid/ready load port. All timing is counted in clk cycles.
// Optional feature macro: INTR_GPIO_GEN_ACK_EN adds level-mode pulses that stay
// active until an ack input is sampled high (ports ack, cfg_level).
module intr_gpio_gen #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 20,
  parameter int CHAN_W    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_idle,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 cfg_pol,
  input  logic [CHANNELS-1:0]  stop,
  output logic [CHANNELS-1:0]  gpio,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  done
`ifdef INTR_GPIO_GEN_ACK_EN
  ,
  input  logic [CHANNELS-1:0]  ack,
  input  logic                 cfg_level
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CHANNELS-1:0] w_is_idle;
  logic                w_ready;
  logic                w_accept;

  // Ready reflects only the addressed channel; an out-of-range index never
  // matches, and a same-cycle stop on the target channel blocks the accept.
  always_comb begin
    w_ready = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) begin
        w_ready = w_is_idle[i] && !stop[i];
      end
    end
  end

  assign cfg_ready = w_ready;
  assign w_accept  = cfg_valid && w_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    state_t               r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [CNT_WIDTH-1:0] r_rem, w_rem_next;
    logic [CNT_WIDTH-1:0] r_idle, w_idle_next;
    logic [CNT_WIDTH-1:0] r_width, w_width_next;
    logic                 r_pol, w_pol_next;
    logic                 r_gpio, w_gpio_next;
    logic                 r_done, w_done_next;
    logic                 w_fire;
    logic                 w_pulse_end;
`ifdef INTR_GPIO_GEN_ACK_EN
    logic                 r_level, w_level_next;

    // Level-mode pulses end on ack; width-timed pulses end when cnt runs out.
    assign w_pulse_end = r_level ? ack[gi] : (r_cnt == '0);
`else
    assign w_pulse_end = (r_cnt == '0);
`endif

    assign w_fire = w_accept && (cfg_chan == CHAN_W'(gi));

    // Channel state register; gpio drops to 0 asynchronously on reset.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_rem   <= '0;
        r_idle  <= '0;
        r_width <= '0;
        r_pol   <= 1'b1;
        r_gpio  <= 1'b0;
        r_done  <= 1'b0;
`ifdef INTR_GPIO_GEN_ACK_EN
        r_level <= 1'b0;
`endif
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        r_rem   <= w_rem_next;
        r_idle  <= w_idle_next;
        r_width <= w_width_next;
        r_pol   <= w_pol_next;
        r_gpio  <= w_gpio_next;
        r_done  <= w_done_next;
`ifdef INTR_GPIO_GEN_ACK_EN
        r_level <= w_level_next;
`endif
      end
    end

    // Next-state logic: stop wins, then config accept, then the normal
    // WAIT/PULSE sequencing. Counters only decrement while non-zero.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_rem_next   = r_rem;
      w_idle_next  = r_idle;
      w_width_next = r_width;
      w_pol_next   = r_pol;
      w_gpio_next  = r_gpio;
      w_done_next  = 1'b0;
`ifdef INTR_GPIO_GEN_ACK_EN
      w_level_next = r_level;
`endif
      if (stop[gi]) begin
        w_state_next = S_IDLE;
        w_gpio_next  = ~r_pol;
      end else if (w_fire) begin
        w_idle_next  = cfg_idle;
        w_width_next = cfg_width;
        w_pol_next   = cfg_pol;
        w_cnt_next   = cfg_idle;
        w_rem_next   = cfg_count;
        w_gpio_next  = ~cfg_pol;
        w_state_next = S_WAIT;
`ifdef INTR_GPIO_GEN_ACK_EN
        w_level_next = cfg_level;
`endif
      end else begin
        case (r_state)
          S_WAIT: begin
            if (r_cnt != '0) begin
              w_cnt_next = r_cnt - CNT_ONE;
            end else begin
              // A zero width still produces a one-cycle pulse.
              w_cnt_next   = (r_width == '0) ? '0 : (r_width - CNT_ONE);
              w_gpio_next  = r_pol;
              w_state_next = S_PULSE;
            end
          end
          S_PULSE: begin
            if (w_pulse_end) begin
              w_gpio_next = ~r_pol;
              if (r_rem == CNT_ONE) begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
              end else begin
                // rem == 0 means an endless train; it is never decremented.
                w_state_next = S_WAIT;
                w_cnt_next   = r_idle;
                if (r_rem != '0) begin
                  w_rem_next = r_rem - CNT_ONE;
                end
              end
            end else if (r_cnt != '0) begin
              w_cnt_next = r_cnt - CNT_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end

    assign gpio[gi]      = r_gpio;
    assign busy[gi]      = (r_state != S_IDLE);
    assign done[gi]      = r_done;
    assign w_is_idle[gi] = (r_state == S_IDLE);
  end

endmodule

// File: tb/tb_intr_gpio_gen.sv
// tb_intr_gpio_gen: directed self-checking bench for intr_gpio_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_intr_gpio_gen;

  localparam int CH  = 4;
  localparam int CW  = 20;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_chan;
  logic [CW-1:0]  cfg_idle;
  logic [CW-1:0]  cfg_width;
  logic [CW-1:0]  cfg_count;
  logic           cfg_pol;
  logic [CH-1:0]  stop;
  logic [CH-1:0]  gpio;
  logic [CH-1:0]  busy;
  logic [CH-1:0]  done;
`ifdef INTR_GPIO_GEN_ACK_EN
  logic [CH-1:0]  ack;
  logic           cfg_level;
`endif

  int checks = 0;
  int errors = 0;

  intr_gpio_gen #(.CHANNELS(CH), .CNT_WIDTH(CW), .CHAN_W(CHW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_idle  (cfg_idle),
    .cfg_width (cfg_width),
    .cfg_count (cfg_count),
    .cfg_pol   (cfg_pol),
    .stop      (stop),
    .gpio      (gpio),
    .busy      (busy),
    .done      (done)
`ifdef INTR_GPIO_GEN_ACK_EN
    ,
    .ack       (ack),
    .cfg_level (cfg_level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, obs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_set(input logic [CHW-1:0] c, input logic [CW-1:0] idl,
                         input logic [CW-1:0] wid, input logic [CW-1:0] cnt,
                         input logic pol);
    cfg_chan  = c;
    cfg_idle  = idl;
    cfg_width = wid;
    cfg_count = cnt;
    cfg_pol   = pol;
    cfg_valid = 1'b1;
    #1;
  endtask

  logic [63:0] tr_g0, tr_d0, tr_b0, tr_g3, tr_d3, tr_b3;
  logic [63:0] ex_g0, ex_d0, ex_b0, ex_g3, ex_d3, ex_b3;
  int          mism, done_hits, rises;
  logic        prev_g;
  logic        exp_g;

  initial begin
    resetn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_idle  = '0;
    cfg_width = '0;
    cfg_count = '0;
    cfg_pol   = 1'b1;
    stop      = '0;
`ifdef INTR_GPIO_GEN_ACK_EN
    ack       = '0;
    cfg_level = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_gpio", 64'(gpio), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_ch0_idle", 64'(cfg_ready), 64'h1);

    // Out-of-range channel index: never ready, never starts anything.
    cfg_set(3'd5, 20'd1, 20'd1, 20'd1, 1'b1);
    chk("ready_chan5", 64'(cfg_ready), 64'h0);
    cycle();
    cfg_valid = 1'b0;
    chk("busy_after_chan5", 64'(busy), 64'h0);

    // ch0 single pulse, busy reconfig attempt, ch3 accepted on ch0 pulse end.
    cfg_set(3'd0, 20'd10, 20'd5, 20'd1, 1'b1);
    chk("ready_ch0_cfg", 64'(cfg_ready), 64'h1);
    cycle();
    cfg_valid = 1'b0;
    chk("ch0_busy_T", 64'(busy[0]), 64'h1);
    tr_g0 = '0; tr_d0 = '0; tr_b0 = '0; tr_g3 = '0; tr_d3 = '0; tr_b3 = '0;
    ex_g0 = '0; ex_d0 = '0; ex_b0 = '0; ex_g3 = '0; ex_d3 = '0; ex_b3 = '0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) begin
        cfg_set(3'd0, 20'd1, 20'd1, 20'd1, 1'b0);
        chk("ready_ch0_busy", 64'(cfg_ready), 64'h0);
      end
      if (k == 6) cfg_valid = 1'b0;
      if (k == 16) begin
        cfg_set(3'd3, 20'd2, 20'd3, 20'd1, 1'b1);
        chk("ready_ch3", 64'(cfg_ready), 64'h1);
      end
      if (k == 17) cfg_valid = 1'b0;
      cycle();
      tr_g0[k] = gpio[0]; tr_d0[k] = done[0]; tr_b0[k] = busy[0];
      tr_g3[k] = gpio[3]; tr_d3[k] = done[3]; tr_b3[k] = busy[3];
      ex_g0[k] = (k >= 11 && k <= 15);
      ex_d0[k] = (k == 16);
      ex_b0[k] = (k < 16);
      ex_g3[k] = (k >= 19 && k <= 21);
      ex_d3[k] = (k == 22);
      ex_b3[k] = (k >= 16 && k < 22);
    end
    chk("ch0_gpio_trace", tr_g0, ex_g0);
    chk("ch0_done_trace", tr_d0, ex_d0);
    chk("ch0_busy_trace", tr_b0, ex_b0);
    chk("ch3_gpio_trace", tr_g3, ex_g3);
    chk("ch3_done_trace", tr_d3, ex_d3);
    chk("ch3_busy_trace", tr_b3, ex_b3);

    // ch1 active-low, zero idle/width, three pulses.
    cfg_set(3'd1, 20'd0, 20'd0, 20'd3, 1'b0);
    cycle();
    cfg_valid = 1'b0;
    chk("ch1_inactive_high", 64'(gpio[1]), 64'h1);
    tr_g0 = '0; tr_d0 = '0; tr_b0 = '0;
    ex_g0 = '0; ex_d0 = '0; ex_b0 = '0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tr_g0[k] = gpio[1]; tr_d0[k] = done[1]; tr_b0[k] = busy[1];
      ex_g0[k] = (k <= 5) ? (k % 2 == 0) : 1'b1;
      ex_d0[k] = (k == 6);
      ex_b0[k] = (k < 6);
    end
    chk("ch1_gpio_trace", tr_g0, ex_g0);
    chk("ch1_done_trace", tr_d0, ex_d0);
    chk("ch1_busy_trace", tr_b0, ex_b0);

    // ch2 infinite train, period 7, then stop during a pulse.
    cfg_set(3'd2, 20'd4, 20'd2, 20'd0, 1'b1);
    cycle();
    cfg_valid = 1'b0;
    mism = 0; done_hits = 0; rises = 0; prev_g = gpio[2];
    for (int k = 1; k <= 110; k++) begin
      if (k == 104) stop = 4'b0100;
      if (k == 105) stop = 4'b0000;
      cycle();
      exp_g = (k >= 5 && k < 104 && ((k - 5) % 7) < 2);
      if (gpio[2] !== exp_g) mism++;
      if (done[2]) done_hits++;
      if (gpio[2] && !prev_g) rises++;
      prev_g = gpio[2];
      if (k == 103) chk("ch2_in_pulse", 64'(gpio[2]), 64'h1);
      if (k == 104) begin
        chk("ch2_stop_gpio", 64'(gpio[2]), 64'h0);
        chk("ch2_stop_busy", 64'(busy[2]), 64'h0);
      end
    end
    chk("ch2_period_mism", 64'(mism), 64'h0);
    chk("ch2_pulse_count", 64'(rises), 64'd15);
    chk("ch2_no_done", 64'(done_hits), 64'h0);

    // All channels mid-pulse, then asynchronous reset.
    for (int c = 0; c < CH; c++) begin
      cfg_set(CHW'(c), 20'd0, 20'd50, 20'd0, 1'b1);
      cycle();
    end
    cfg_valid = 1'b0;
    repeat (3) cycle();
    chk("all_pulsing_gpio", 64'(gpio), 64'hF);
    chk("all_pulsing_busy", 64'(busy), 64'hF);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_gpio", 64'(gpio), 64'h0);
    chk("async_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      cfg_chan = CHW'(c);
      #1;
      chk($sformatf("post_rst_ready_ch%0d", c), 64'(cfg_ready), 64'h1);
    end
    chk("post_rst_gpio", 64'(gpio), 64'h0);

`ifdef INTR_GPIO_GEN_ACK_EN
    // Level mode on ch0: held until ack, ack in WAIT ignored.
    cfg_level = 1'b1;
    cfg_set(3'd0, 20'd3, 20'd7, 20'd2, 1'b1);
    cycle();
    cfg_valid = 1'b0;
    cfg_level = 1'b0;
    tr_g0 = '0; tr_d0 = '0;
    ex_g0 = '0; ex_d0 = '0;
    for (int k = 1; k <= 37; k++) begin
      ack = (k == 24 || k == 26 || k == 35) ? 4'b0001 : 4'b0000;
      cycle();
      tr_g0[k] = gpio[0]; tr_d0[k] = done[0];
      ex_g0[k] = (k >= 4 && k <= 23) || (k >= 28 && k <= 34);
      ex_d0[k] = (k == 35);
    end
    ack = '0;
    chk("ack_gpio_trace", tr_g0, ex_g0);
    chk("ack_done_trace", tr_d0, ex_d0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
